// File: rtl/snn_syn_pkg.sv
// Shared widths and state encoding for the synapse averaging path.
// Used by the accumulator and the saturating adder.
package snn_syn_pkg;

    localparam int SYN_WGT_W      = 8;
    localparam int SYN_SUM_W      = 14;
    localparam int SYN_CNT_W      = 13;
    localparam int SYN_WINDOW_LEN = 16;

    typedef enum logic {
        ST_ACCUM   = 1'b0,
        ST_PRESENT = 1'b1
    } syn_state_e;

endpackage

// File: rtl/sat_adder.sv
// Unsigned saturating add of a weight onto a running sum.
// Reports whether the result was clipped to the all-ones maximum.
module sat_adder
    import snn_syn_pkg::*;
#(
    parameter int SUM_W = SYN_SUM_W,
    parameter int WGT_W = SYN_WGT_W
) (
    input  logic [SUM_W-1:0] a,
    input  logic [WGT_W-1:0] b,
    output logic [SUM_W-1:0] sum,
    output logic             clip
);

    localparam int RAW_W = SUM_W + 1;

    logic [SUM_W:0] raw;

    assign raw  = {1'b0, a} + RAW_W'(b);
    assign clip = raw[SUM_W];
    assign sum  = clip ? '1 : raw[SUM_W-1:0];

endmodule

// File: rtl/synapse_accumulator.sv
// Windowed weight accumulator with valid/ready result hand-off.
// Define SYN_ACC_SAT_FLAG_EN to expose the per-window saturation flag port.
module synapse_accumulator
    import snn_syn_pkg::*;
#(
    parameter int WGT_W      = SYN_WGT_W,
    parameter int SUM_W      = SYN_SUM_W,
    parameter int CNT_W      = SYN_CNT_W,
    parameter int WINDOW_LEN = SYN_WINDOW_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WGT_W-1:0] in_weight,
    input  logic             in_last,
    input  logic             flush,
    output logic             in_ready,
    output logic [SUM_W-1:0] info,
    output logic [CNT_W-1:0] divisor,
    output logic             valid,
`ifdef SYN_ACC_SAT_FLAG_EN
    output logic             sat,
`endif
    input  logic             ready
);

    if (WINDOW_LEN < 1 || WINDOW_LEN > (2 ** CNT_W) - 1) begin : g_bad_window
        $error("synapse_accumulator: WINDOW_LEN out of range");
    end

    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WINDOW_LEN);

    syn_state_e       state, state_next;
    logic [SUM_W-1:0] sum, sum_next;
    logic [CNT_W-1:0] count, count_next;
    logic             win_sat, win_sat_next;
    logic [SUM_W-1:0] info_q, info_next;
    logic [CNT_W-1:0] div_q, div_next;
    logic             valid_q, valid_next;
    logic             sat_q, sat_next;

    logic [SUM_W-1:0] add_sum;
    logic             add_clip;
    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_sat;
    logic             close;

    sat_adder #(
        .SUM_W(SUM_W),
        .WGT_W(WGT_W)
    ) u_add (
        .a   (sum),
        .b   (in_weight),
        .sum (add_sum),
        .clip(add_clip)
    );

    always_comb begin
        state_next   = state;
        sum_next     = sum;
        count_next   = count;
        win_sat_next = win_sat;
        info_next    = info_q;
        div_next     = div_q;
        valid_next   = valid_q;
        sat_next     = sat_q;
        acc_sum      = sum;
        acc_cnt      = count;
        acc_sat      = win_sat;
        close        = 1'b0;
        unique case (state)
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_sum = add_sum;
                    acc_cnt = count + 1'b1;
                    acc_sat = win_sat | add_clip;
                end
                // an empty window never closes, so divisor is never zero
                close = (in_valid && (in_last || acc_cnt == WIN_CNT))
                      || (flush && acc_cnt != '0);
                sum_next     = acc_sum;
                count_next   = acc_cnt;
                win_sat_next = acc_sat;
                if (close) begin
                    info_next    = acc_sum;
                    div_next     = acc_cnt;
                    sat_next     = acc_sat;
                    valid_next   = 1'b1;
                    sum_next     = '0;
                    count_next   = '0;
                    win_sat_next = 1'b0;
                    state_next   = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (ready) begin
                    valid_next = 1'b0;
                    sat_next   = 1'b0;
                    state_next = ST_ACCUM;
                end
            end
            default: state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_ACCUM;
            sum     <= '0;
            count   <= '0;
            win_sat <= 1'b0;
            info_q  <= '0;
            div_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state   <= state_next;
            sum     <= sum_next;
            count   <= count_next;
            win_sat <= win_sat_next;
            info_q  <= info_next;
            div_q   <= div_next;
            valid_q <= valid_next;
            sat_q   <= sat_next;
        end
    end

    assign in_ready = (state == ST_ACCUM);
    assign info     = info_q;
    assign divisor  = div_q;
    assign valid    = valid_q;

`ifdef SYN_ACC_SAT_FLAG_EN
    assign sat = sat_q;
`else
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_synapse_accumulator.sv
// Scoreboard bench for synapse_accumulator (default and WINDOW_LEN=100).
// Monitors pop expected results whenever a valid/ready transfer is seen.
module tb_synapse_accumulator;

    typedef struct {
        int info;
        int div;
        bit sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        a_in_valid = 0, a_in_last = 0, a_flush = 0, a_ready = 0;
    logic [7:0]  a_in_weight = 0;
    logic        a_in_ready, a_valid;
    logic [13:0] a_info;
    logic [12:0] a_divisor;

    logic        b_in_valid = 0, b_in_last = 0, b_flush = 0, b_ready = 0;
    logic [7:0]  b_in_weight = 0;
    logic        b_in_ready, b_valid;
    logic [13:0] b_info;
    logic [12:0] b_divisor;

`ifdef SYN_ACC_SAT_FLAG_EN
    logic a_sat, b_sat;
`endif

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    synapse_accumulator dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_weight(a_in_weight),
        .in_last(a_in_last), .flush(a_flush),
        .in_ready(a_in_ready), .info(a_info),
        .divisor(a_divisor), .valid(a_valid),
`ifdef SYN_ACC_SAT_FLAG_EN
        .sat(a_sat),
`endif
        .ready(a_ready)
    );

    synapse_accumulator #(.WINDOW_LEN(100)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_weight(b_in_weight),
        .in_last(b_in_last), .flush(b_flush),
        .in_ready(b_in_ready), .info(b_info),
        .divisor(b_divisor), .valid(b_valid),
`ifdef SYN_ACC_SAT_FLAG_EN
        .sat(b_sat),
`endif
        .ready(b_ready)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int i, input int d, input bit s);
        exp_t e;
        e.info = i; e.div = d; e.sat = s;
        qa.push_back(e);
    endtask

    task automatic send_a(input int w, input bit last);
        a_in_valid = 1; a_in_weight = 8'(w); a_in_last = last;
        tick();
        a_in_valid = 0; a_in_last = 0;
    endtask

    task automatic send_b(input int w);
        b_in_valid = 1; b_in_weight = 8'(w);
        tick();
        b_in_valid = 0;
    endtask

    always @(negedge clk) begin
        if (reset && a_valid && a_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_info", a_info, e.info);
                chk("a_divisor", a_divisor, e.div);
`ifdef SYN_ACC_SAT_FLAG_EN
                chk("a_sat", a_sat, e.sat);
`endif
            end
        end
        if (reset && b_valid && b_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_info", b_info, e.info);
                chk("b_divisor", b_divisor, e.div);
`ifdef SYN_ACC_SAT_FLAG_EN
                chk("b_sat", b_sat, e.sat);
`endif
            end
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_valid", a_valid, 0);
        chk("rst_info", a_info, 0);
        chk("rst_divisor", a_divisor, 0);
        chk("rst_b_valid", b_valid, 0);
        reset = 1;
        a_ready = 1;
        tick();

        // two-event window closed by in_last
        push_a(27, 2, 0);
        send_a(9, 0);
        send_a(18, 1);
        chk("t1_valid", a_valid, 1);
        chk("t1_in_ready_busy", a_in_ready, 0);
        tick();
        chk("t1_valid_drop", a_valid, 0);
        chk("t1_in_ready_back", a_in_ready, 1);

        // auto-close at WINDOW_LEN, then a fresh window
        push_a(48, 16, 0);
        for (int i = 0; i < 16; i++) send_a(3, 0);
        chk("t2_autoclose_valid", a_valid, 1);
        tick();
        push_a(3, 1, 0);
        send_a(3, 1);
        tick();
        chk("t2_second_done", a_valid, 0);

        // back-pressure: result held, upstream ignored
        a_ready = 0;
        push_a(5, 1, 0);
        send_a(5, 1);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1; a_in_weight = 8'd99; a_flush = 1;
            chk("t4_valid_held", a_valid, 1);
            chk("t4_info_held", a_info, 5);
            chk("t4_div_held", a_divisor, 1);
            chk("t4_in_ready_low", a_in_ready, 0);
            tick();
        end
        a_in_valid = 0; a_flush = 0;
        a_ready = 1;
        tick();
        chk("t4_transfer", a_valid, 0);
        push_a(1, 1, 0);
        send_a(1, 1);
        tick();

        // flush on empty window does nothing
        a_flush = 1;
        tick();
        a_flush = 0;
        for (int i = 0; i < 10; i++) begin
            chk("t5_no_valid", a_valid, 0);
            chk("t5_in_ready", a_in_ready, 1);
            tick();
        end

        // reset mid-window discards partial sum
        for (int i = 0; i < 3; i++) send_a(7, 0);
        reset = 0;
        #1;
        chk("t6_rst_valid", a_valid, 0);
        chk("t6_rst_info", a_info, 0);
        chk("t6_rst_div", a_divisor, 0);
        chk("t6_rst_in_ready", a_in_ready, 1);
        tick();
        tick();
        reset = 1;
        push_a(5, 1, 0);
        send_a(5, 1);
        tick();

        // long window saturating, closed by flush
        b_ready = 1;
        for (int i = 0; i < 70; i++) send_b(255);
        chk("t3_not_closed", b_valid, 0);
        begin
            exp_t e;
            e.info = 16383; e.div = 70; e.sat = 1;
            qb.push_back(e);
        end
        b_flush = 1;
        tick();
        b_flush = 0;
        chk("t3_flush_valid", b_valid, 1);
        tick();

        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/synapse_accumulator.md
Name: synapse_accumulator

Overview:
- Upstream stage of the synapse averaging path.
- Collects weighted spike events over a window, then presents the window sum (info) and event count (divisor) to the propagater stage through a valid/ready handshake.
- Holds each result until the downstream stage accepts it, then opens a new window.

Parameters:
WGT_W, 8, width of one incoming synaptic weight (unsigned)
SUM_W, 14, width of accumulated sum / info output
CNT_W, 13, width of event count / divisor output
WINDOW_LEN, 16, events per window before auto-close; legal range 1..2^CNT_W-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  weight event present this cycle
in_weight  input  WGT_W  unsigned weight of the event
in_last  input  1  closes window with this event; sampled only when in_valid=1
flush  input  1  closes current window without adding an event
in_ready  output  1  block accepts events this cycle
info  output  SUM_W  window sum, stable while valid=1
divisor  output  CNT_W  window event count, stable while valid=1, never 0 when valid=1
valid  output  1  result available for the propagater
ready  input  1  propagater accepts result

Behaviour:
- Reset (reset=0, async):
  - state=ACCUM; sum=0, count=0, sat=0.
  - Outputs: in_ready=1, valid=0, info=0, divisor=0.
  - Any partial window or unaccepted result is discarded.
- State ACCUM:
  - in_ready=1.
  - An event is accepted when in_valid=1.
  - Update: sum_next = min(sum+in_weight, 2^SUM_W-1); count_next = count+1.
  - Close when: in_last=1, or count_next==WINDOW_LEN, or flush=1 with count>0.
  - On close: info<=sum_next, divisor<=count_next, valid<=1, sum<=0, count<=0, state<=PRESENT.
    - With flush and no event, sum_next/count_next are the current sum/count.
  - flush with in_valid=1: the event is included, then the window closes.
  - flush with count=0 and in_valid=0: no effect; no zero-divisor result is ever produced.
- State PRESENT:
  - in_ready=0; valid=1; info/divisor held.
  - Transfer occurs on a rising edge with valid=1 and ready=1.
  - After transfer: valid<=0, state<=ACCUM, in_ready=1 from the next cycle.
  - in_valid and flush are ignored; upstream must honour in_ready.
- Latency: result is visible 1 cycle after the closing edge. Minimum spacing between results is 2 cycles (window of 1 plus immediate ready).
- Arithmetic:
  - Weights are zero-extended to SUM_W.
  - Saturation is sticky per window: once the sum reaches 2^SUM_W-1, it stays there until the window closes.
  - count cannot overflow because WINDOW_LEN < 2^CNT_W.
- ready asserted while valid=0 has no effect.
- Parameter check: elaboration-time error if WINDOW_LEN==0 or WINDOW_LEN>2^CNT_W-1.

Optional Feature:
SYN_ACC_SAT_FLAG_EN
- Defined:
  - Adds output port `sat` (1 bit).
  - Set together with valid when any addition in the window clipped.
  - Held while valid=1; cleared on transfer and on reset.
- Undefined:
  - Port absent; saturation is silent.
  - Datapath behaviour is otherwise identical.

Decomposition:
- Shared package snn_syn_pkg:
  - width constants SYN_WGT_W=8, SYN_SUM_W=14, SYN_CNT_W=13
  - default SYN_WINDOW_LEN=16
  - state encoding localparams ST_ACCUM, ST_PRESENT
- One sub-module: sat_adder.
  - Unsigned SUM_W + WGT_W saturating add.
  - Outputs the clipped sum and a clip flag.
  - Reused later by the weight-update path.
- FSM and registers stay in synapse_accumulator.

Test Plan:
- Weights 9 then 18 (in_last on second), ready=1 -> next cycle valid=1, info=27, divisor=2; valid=0 one cycle later; in_ready=1 again.
- Default WINDOW_LEN=16, sixteen weight-3 events, no in_last -> auto-close: info=48, divisor=16; 17th event lands in a new window.
- WINDOW_LEN=100, seventy weight-255 events then flush -> info=16383, divisor=70; sat=1 when SYN_ACC_SAT_FLAG_EN defined.
- Close window (info=5, divisor=1), hold ready=0 for 5 cycles while driving in_valid -> valid, info and divisor stable; in_ready=0; no events counted; ready=1 -> transfer, next window starts empty.
- flush pulse with empty window -> valid stays 0 for 10 cycles, in_ready stays 1.
- Three events of weight 7, then reset=0 for 2 cycles mid-window -> all outputs at reset values; after release, weight 5 with in_last -> info=5, divisor=1.
